// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and sizing helper for the bounce_shifter scanner.
//   mode_t    : runtime scan mode (bounce / rotate-left / rotate-right / freeze)
//   state_t   : top-level FSM states (start hold, running)
//   cnt_width : bits needed to hold the values 0..n-1 (never less than 1)
// No ports (package).
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    typedef enum logic {
        S_START = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // A counter that only ever holds 0 still needs one physical bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bounce_shifter_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Modulo-DWELL counter that decides when the scanner may move to its next
// position. The counter only advances on tick, so a stalled scanner keeps
// its place inside the dwell period.
// Parameters:
//   DWELL : cycles spent on each position (>= 1)
// Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous, active-high reset (counter to 0)
//   tick  in  one enabled running cycle
//   step  out single-cycle pulse on the last tick of a dwell period
// ---------------------------------------------------------------------------
module dwell_timer
    import shift_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic step
);

    localparam int            CW   = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign step = tick && (cnt == LAST);

endmodule

// File: rtl/bounce_shifter.sv
// ---------------------------------------------------------------------------
// bounce_shifter
// One-hot position scanner: a single lit bit walks across a WIDTH-bit vector,
// either bouncing between the ends or rotating in either direction. After
// reset bit0 is held for START_HOLD enabled cycles, then every position is
// shown for DWELL enabled cycles.
// Parameters:
//   WIDTH      : number of positions (>= 2)
//   START_HOLD : enabled cycles bit0 is held after reset (0 = no hold)
//   DWELL      : enabled cycles per position while running (>= 1)
// Ports:
//   clk     in  rising-edge clock
//   reset   in  synchronous, active-high reset; overrides all other inputs
//   en      in  advance enable; low freezes all state
//   mode    in  00 bounce, 01 rotate-left, 10 rotate-right, 11 freeze
//   count   out one-hot position (1 << pos)
//   dir     out 1 = moving toward MSB, 0 = toward LSB
//   end_hit out 1-cycle pulse when pos has just stepped onto 0 or WIDTH-1
//   pos     out binary index of the lit bit (only with SHIFT_POS_EN)
// Build option:
//   SHIFT_POS_EN : when defined, adds the registered pos output port.
// ---------------------------------------------------------------------------
module bounce_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int START_HOLD = 4,
    parameter int DWELL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             end_hit
`ifdef SHIFT_POS_EN
    ,
    output logic [$clog2(WIDTH)-1:0] pos
`endif
);

    localparam int            PW         = $clog2(WIDTH);
    localparam int            SW         = cnt_width(START_HOLD);
    localparam logic [PW-1:0] POS_MAX    = PW'(WIDTH - 1);
    localparam logic [SW-1:0] START_LAST = SW'((START_HOLD > 0) ? START_HOLD - 1 : 0);

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] start_q;
    logic [SW-1:0] start_d;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic [PW-1:0] step_pos;
    logic          dir_q;
    logic          dir_d;
    logic          step_dir;
    logic          active;
    logic          dwell_step;
    logic          do_step;
    mode_t         cur_mode;

    assign cur_mode = mode_t'(mode);
    assign active   = en && (cur_mode != MODE_FREEZE);
    assign dir      = dir_q;

`ifdef SHIFT_POS_EN
    assign pos = pos_q;
`endif

    // The dwell timer only runs once the start hold is over, so it sits at 0
    // when the first step out of S_START happens.
    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk  (clk),
        .reset(reset),
        .tick (active && (state_q == S_RUN)),
        .step (dwell_step)
    );

    // Where the lit bit would go if a step happened this cycle. The mode is
    // only consulted here, so a mode change takes effect at the next step.
    always_comb begin
        step_pos = pos_q;
        step_dir = dir_q;
        case (cur_mode)
            MODE_ROT_L: begin
                step_dir = 1'b1;
                step_pos = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
            end
            MODE_ROT_R: begin
                step_dir = 1'b0;
                step_pos = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
            end
            default: begin
                // Bounce turns around on the end position itself, so each end
                // is shown once per pass. Freeze never steps.
                if (dir_q) begin
                    if (pos_q == POS_MAX) begin
                        step_pos = POS_MAX - 1'b1;
                        step_dir = 1'b0;
                    end else begin
                        step_pos = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        step_pos = PW'(1);
                        step_dir = 1'b1;
                    end else begin
                        step_pos = pos_q - 1'b1;
                    end
                end
            end
        endcase
    end

    // Start-hold / run sequencing and the decision to step.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        do_step = 1'b0;
        if (active) begin
            case (state_q)
                S_START: begin
                    start_d = start_q + 1'b1;
                    if (start_q == START_LAST) begin
                        state_d = S_RUN;
                        do_step = 1'b1;
                    end
                end
                default: begin
                    do_step = dwell_step;
                end
            endcase
        end
        pos_d = do_step ? step_pos : pos_q;
        dir_d = do_step ? step_dir : dir_q;
    end

    // State register. count is rebuilt from the next position so it always
    // has the same timing as pos and can never be zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (START_HOLD == 0) begin
                state_q <= S_RUN;
            end else begin
                state_q <= S_START;
            end
            start_q <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            count   <= WIDTH'(1);
            end_hit <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            count   <= WIDTH'(1) << pos_d;
            end_hit <= do_step && ((step_pos == '0) || (step_pos == POS_MAX));
        end
    end

endmodule

// File: tb/tb_bounce_shifter.sv
// ---------------------------------------------------------------------------
// tb_bounce_shifter
// Scoreboard bench for bounce_shifter. Two instances share the inputs:
//   dutA : WIDTH=8, START_HOLD=4, DWELL=1
//   dutB : WIDTH=8, START_HOLD=0, DWELL=3
// Stimulus pushes hand-computed expected outputs into a queue ahead of each
// clock edge; the monitor pops one entry after every edge and compares.
// ---------------------------------------------------------------------------
module tb_bounce_shifter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [1:0] mode  = 2'b00;

    logic [7:0] countA;
    logic [7:0] countB;
    logic       dirA;
    logic       dirB;
    logic       endA;
    logic       endB;
`ifdef SHIFT_POS_EN
    logic [2:0] posA;
    logic [2:0] posB;
`endif

    typedef struct {
        bit         chkA;
        logic [7:0] cA;
        logic       dA;
        logic       eA;
        bit         chkB;
        logic [7:0] cB;
        logic       dB;
        logic       eB;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bounce_shifter #(.WIDTH(8), .START_HOLD(4), .DWELL(1)) dutA (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .count  (countA),
        .dir    (dirA),
        .end_hit(endA)
`ifdef SHIFT_POS_EN
        ,
        .pos    (posA)
`endif
    );

    bounce_shifter #(.WIDTH(8), .START_HOLD(0), .DWELL(3)) dutB (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .count  (countB),
        .dir    (dirB),
        .end_hit(endB)
`ifdef SHIFT_POS_EN
        ,
        .pos    (posB)
`endif
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] indexOf(input logic [7:0] c);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) r = 8'(i);
        end
        return r;
    endfunction

    // Monitor: one scoreboard entry per clock edge, sampled 1 time unit later.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chkA) begin
                checkOutput({e.tag, "/A count"}, countA, e.cA);
                checkOutput({e.tag, "/A dir"}, {7'd0, dirA}, {7'd0, e.dA});
                checkOutput({e.tag, "/A end_hit"}, {7'd0, endA}, {7'd0, e.eA});
                checkOutput({e.tag, "/A onehot"}, {7'd0, $onehot(countA)}, 8'd1);
`ifdef SHIFT_POS_EN
                checkOutput({e.tag, "/A pos"}, {5'd0, posA}, indexOf(e.cA));
`endif
            end
            if (e.chkB) begin
                checkOutput({e.tag, "/B count"}, countB, e.cB);
                checkOutput({e.tag, "/B dir"}, {7'd0, dirB}, {7'd0, e.dB});
                checkOutput({e.tag, "/B end_hit"}, {7'd0, endB}, {7'd0, e.eB});
`ifdef SHIFT_POS_EN
                checkOutput({e.tag, "/B pos"}, {5'd0, posB}, indexOf(e.cB));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input bit chkA, input logic [7:0] cA, input logic dA, input logic eA,
                                 input bit chkB, input logic [7:0] cB, input logic dB, input logic eB,
                                 input string tag);
        exp_t x;
        @(negedge clk);
        reset = r;
        en    = e;
        mode  = m;
        x.chkA = chkA; x.cA = cA; x.dA = dA; x.eA = eA;
        x.chkB = chkB; x.cB = cB; x.dB = dB; x.eB = eB;
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic stepA(input logic e, input logic [1:0] m, input logic [7:0] c,
                         input logic d, input logic h, input string tag);
        applyStimulus(1'b0, e, m, 1'b1, c, d, h, 1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic stepB(input logic e, input logic [1:0] m, input logic [7:0] c,
                         input logic d, input logic h, input string tag);
        applyStimulus(1'b0, e, m, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, c, d, h, tag);
    endtask

    initial begin
        // Dwell of 3 without start hold, plus a stall mid-dwell on dutB.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "reset");
        repeat (2) stepB(1'b1, 2'b00, 8'h01, 1'b1, 1'b0, "dwellB");
        repeat (3) stepB(1'b1, 2'b00, 8'h02, 1'b1, 1'b0, "dwellB");
        repeat (2) stepB(1'b1, 2'b00, 8'h04, 1'b1, 1'b0, "dwellB");
        repeat (5) stepB(1'b0, 2'b00, 8'h04, 1'b1, 1'b0, "enholdB");
        stepB(1'b1, 2'b00, 8'h04, 1'b1, 1'b0, "resumeB");
        repeat (3) stepB(1'b1, 2'b00, 8'h08, 1'b1, 1'b0, "resumeB");
        stepB(1'b1, 2'b00, 8'h10, 1'b1, 1'b0, "resumeB");

        // Start hold and full bounce pass on dutA.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "reset2");
        repeat (3) stepA(1'b1, 2'b00, 8'h01, 1'b1, 1'b0, "hold");
        for (int i = 1; i <= 6; i++) stepA(1'b1, 2'b00, 8'(1 << i), 1'b1, 1'b0, "up");
        stepA(1'b1, 2'b00, 8'h80, 1'b1, 1'b1, "top");
        for (int i = 6; i >= 1; i--) stepA(1'b1, 2'b00, 8'(1 << i), 1'b0, 1'b0, "down");
        stepA(1'b1, 2'b00, 8'h01, 1'b0, 1'b1, "bottom");
        stepA(1'b1, 2'b00, 8'h02, 1'b1, 1'b0, "turn");
        for (int i = 2; i <= 6; i++) stepA(1'b1, 2'b00, 8'(1 << i), 1'b1, 1'b0, "up2");
        stepA(1'b1, 2'b00, 8'h80, 1'b1, 1'b1, "top2");

        // Rotation wrap-arounds.
        stepA(1'b1, 2'b01, 8'h01, 1'b1, 1'b1, "rotL wrap");
        stepA(1'b1, 2'b10, 8'h80, 1'b0, 1'b1, "rotR wrap");
        stepA(1'b1, 2'b10, 8'h40, 1'b0, 1'b0, "rotR");
        stepA(1'b1, 2'b10, 8'h20, 1'b0, 1'b0, "rotR");
        stepA(1'b1, 2'b10, 8'h10, 1'b0, 1'b0, "rotR");

        // Enable low, then freeze mode, then bounce keeping direction.
        repeat (5) stepA(1'b0, 2'b10, 8'h10, 1'b0, 1'b0, "en low");
        stepA(1'b1, 2'b10, 8'h08, 1'b0, 1'b0, "resume");
        repeat (5) stepA(1'b1, 2'b11, 8'h08, 1'b0, 1'b0, "freeze");
        stepA(1'b1, 2'b00, 8'h04, 1'b0, 1'b0, "bounce keeps dir");
        stepA(1'b1, 2'b00, 8'h02, 1'b0, 1'b0, "bounce");
        stepA(1'b1, 2'b00, 8'h01, 1'b0, 1'b1, "bottom2");
        stepA(1'b0, 2'b00, 8'h01, 1'b0, 1'b0, "end forced low");
        stepA(1'b1, 2'b00, 8'h02, 1'b1, 1'b0, "turn2");
        for (int i = 2; i <= 5; i++) stepA(1'b1, 2'b00, 8'(1 << i), 1'b1, 1'b0, "up3");

        // Reset at 0x20 with en low / freeze must still win; hold restarts.
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "reset wins");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "rehold");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "rehold");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, "rehold");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, "rehold");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
